// File: rtl/audio_pkg.sv
// Shared types and constants for the audio gain ramp datapath.
// Default widths match the codec path (16-bit samples, 12-bit pots).
package audio_pkg;

    localparam int SAMPLE_W = 16;
    localparam int GAIN_W   = 12;

    typedef logic [GAIN_W-1:0]          gain_t;
    typedef logic signed [SAMPLE_W-1:0] sample_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam gain_t   UNITY_GAIN = gain_t'(1 << (GAIN_W - 1));
    localparam sample_t SAT_MAX    = sample_t'((1 << (SAMPLE_W - 1)) - 1);
    localparam sample_t SAT_MIN    = sample_t'(1 << (SAMPLE_W - 1));

endpackage

// File: rtl/audio_gain_ramp_ramp.sv
// Gain slew limiter: latches the target at frame capture and moves
// cur_gain toward it by at most RAMP_STEP per completed frame.
module gain_ramp
    import audio_pkg::*;
#(
    parameter int VOL_W     = GAIN_W,
    parameter int RAMP_STEP = 64,
    parameter int INV_VOL   = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             step,
    input  logic [VOL_W-1:0] volume,
    input  logic             mute,
    output logic [VOL_W-1:0] cur_gain
);

    localparam logic [VOL_W-1:0] STEP_MAX = VOL_W'(RAMP_STEP);

    logic [VOL_W-1:0] target;
    logic [VOL_W-1:0] tgt_nx;
    logic [VOL_W-1:0] delta;
    logic [VOL_W-1:0] step_amt;
    logic             rising;

    always_comb begin
        tgt_nx = volume;
        if (INV_VOL != 0)
            tgt_nx = ~volume;
        if (mute)
            tgt_nx = '0;
    end

    // Step is clamped to the remaining distance so the ramp never overshoots.
    always_comb begin
        rising   = target > cur_gain;
        delta    = rising ? target - cur_gain : cur_gain - target;
        step_amt = (delta < STEP_MAX) ? delta : STEP_MAX;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            target   <= '0;
            cur_gain <= '0;
        end else begin
            if (load)
                target <= tgt_nx;
            if (step)
                cur_gain <= rising ? cur_gain + step_amt
                                   : cur_gain - step_amt;
        end
    end

endmodule

// File: rtl/audio_gain_ramp.sv
// Multi-channel volume stage: one shared multiplier walks the channels,
// results saturate to the sample width, gain is ramped per frame.
module audio_gain_ramp
    import audio_pkg::*;
#(
    parameter int DATA_W    = SAMPLE_W,
    parameter int VOL_W     = GAIN_W,
    parameter int NCH       = 2,
    parameter int RAMP_STEP = 64,
    parameter int INV_VOL   = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  aud_vld,
    input  logic [NCH*DATA_W-1:0] aud_in,
    input  logic [VOL_W-1:0]      volume,
    input  logic                  mute,
    output logic [NCH*DATA_W-1:0] aud_out,
    output logic                  out_vld,
    output logic                  busy,
    output logic                  ovr,
    output logic                  sat,
    output logic [VOL_W-1:0]      gain
);

    localparam int PW   = DATA_W + VOL_W + 1;
    localparam int CH_W = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int HW   = PW - DATA_W + 1;

    localparam logic [DATA_W-1:0] LIM_MAX = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic [DATA_W-1:0] LIM_MIN = {1'b1, {(DATA_W-1){1'b0}}};

    state_e state, state_nx;

    logic [CH_W-1:0]       ch;
    logic [NCH*DATA_W-1:0] smp_buf;
    logic [NCH*DATA_W-1:0] stg;
    logic [NCH*DATA_W-1:0] stg_nx;
    logic [VOL_W-1:0]      frame_gain;
    logic [VOL_W-1:0]      cur_gain;
    logic                  capture;
    logic                  last_ch;
    logic                  clip;
    logic                  sat_acc;
    logic [HW-1:0]         head;
    logic [DATA_W-1:0]     res;

    logic signed [DATA_W-1:0] smp;
    logic signed [PW-1:0]     prod;
    logic signed [PW-1:0]     shf;

    assign capture = (state == IDLE) && aud_vld;
    assign busy    = (state != IDLE);
    assign ovr     = aud_vld && (state != IDLE);
    assign last_ch = (ch == CH_W'(NCH - 1));
    assign gain    = cur_gain;

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: if (aud_vld) state_nx = MUL;
            MUL:  if (last_ch) state_nx = DONE;
            DONE: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Result fits when all bits above the sample sign bit agree with it.
    always_comb begin
        smp    = smp_buf[ch*DATA_W +: DATA_W];
        prod   = smp * $signed({1'b0, frame_gain});
        shf    = prod >>> (VOL_W - 1);
        head   = shf[PW-1:DATA_W-1];
        clip   = !((&head) || !(|head));
        res    = shf[DATA_W-1:0];
        if (clip)
            res = shf[PW-1] ? LIM_MIN : LIM_MAX;
        stg_nx = stg;
        stg_nx[ch*DATA_W +: DATA_W] = res;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ch         <= '0;
            smp_buf    <= '0;
            stg        <= '0;
            frame_gain <= '0;
            sat_acc    <= 1'b0;
            aud_out    <= '0;
            out_vld    <= 1'b0;
            sat        <= 1'b0;
        end else begin
            out_vld <= 1'b0;
            if (capture) begin
                smp_buf    <= aud_in;
                frame_gain <= cur_gain;
                ch         <= '0;
                sat_acc    <= 1'b0;
            end
            if (state == MUL) begin
                stg     <= stg_nx;
                sat_acc <= sat_acc | clip;
                ch      <= ch + 1'b1;
                if (last_ch) begin
                    aud_out <= stg_nx;
                    sat     <= sat_acc | clip;
                    out_vld <= 1'b1;
                end
            end
        end
    end

    gain_ramp #(
        .VOL_W     (VOL_W),
        .RAMP_STEP (RAMP_STEP),
        .INV_VOL   (INV_VOL)
    ) u_ramp (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (capture),
        .step     (state == DONE),
        .volume   (volume),
        .mute     (mute),
        .cur_gain (cur_gain)
    );

endmodule

// File: tb/tb_audio_gain_ramp.sv
// Scoreboard bench for audio_gain_ramp at default parameters.
module tb_audio_gain_ramp;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        aud_vld = 1'b0;
    logic [31:0] aud_in = '0;
    logic [11:0] volume = '0;
    logic        mute = 1'b0;
    logic [31:0] aud_out;
    logic        out_vld;
    logic        busy;
    logic        ovr;
    logic        sat;
    logic [11:0] gain;

    typedef struct {
        logic [31:0] data;
        logic        sat;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad = 0;
    int   out_seen = 0;
    int   model_gain = 0;
    int   model_tgt = 0;

    audio_gain_ramp #(
        .DATA_W(16), .VOL_W(12), .NCH(2), .RAMP_STEP(64), .INV_VOL(1)
    ) dut (
        .clk(clk), .rst_n(rst_n), .aud_vld(aud_vld), .aud_in(aud_in),
        .volume(volume), .mute(mute), .aud_out(aud_out),
        .out_vld(out_vld), .busy(busy), .ovr(ovr), .sat(sat), .gain(gain)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [16:0] scale(input logic [15:0] s, input int g);
        longint p, r;
        p = longint'($signed(s)) * longint'(g);
        r = p >>> 11;
        if (r > 32767)  return {1'b1, 16'h7FFF};
        if (r < -32768) return {1'b1, 16'h8000};
        return {1'b0, r[15:0]};
    endfunction

    task automatic push_exp(input logic [31:0] din);
        exp_t e;
        logic [16:0] lo, hi;
        lo = scale(din[15:0], model_gain);
        hi = scale(din[31:16], model_gain);
        e.data = {hi[15:0], lo[15:0]};
        e.sat  = lo[16] | hi[16];
        sb.push_back(e);
        model_tgt = mute ? 0 : 4095 - int'(volume);
    endtask

    task automatic model_step();
        int d;
        d = (model_tgt > model_gain) ? model_tgt - model_gain
                                     : model_gain - model_tgt;
        if (d > 64) d = 64;
        model_gain += (model_tgt > model_gain) ? d : -d;
    endtask

    task automatic run_frame(input logic [31:0] din);
        int  s;
        bit  seen;
        s = out_seen;
        seen = 0;
        push_exp(din);
        @(negedge clk);
        aud_in  = din;
        aud_vld = 1'b1;
        @(negedge clk);
        aud_vld = 1'b0;
        for (int i = 0; i < 8 && !seen; i++) begin
            @(negedge clk);
            #1;
            if (out_seen != s) seen = 1;
        end
        if (!seen) chk("out_timeout", 0, 1);
        @(negedge clk);
        model_step();
        #1 chk("gain", gain, model_gain);
    endtask

    always @(negedge clk) begin
        if (rst_n && out_vld) begin
            exp_t e;
            out_seen++;
            if (sb.size() == 0) begin
                chk("unexp_out", 1, 0);
            end else begin
                e = sb.pop_front();
                chk("aud_out", aud_out, e.data);
                chk("sat", sat, e.sat);
            end
        end
    end

    initial begin
        int s;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_out", aud_out, 0);
        chk("rst_vld", out_vld, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ovr", ovr, 0);
        chk("rst_sat", sat, 0);
        chk("rst_gain", gain, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // fade in to unity
        volume = 12'd2047;
        for (int i = 0; i < 32; i++) run_frame(32'hEDCC_1234);
        chk("unity_gain", gain, 12'd2048);
        run_frame(32'hEDCC_1234);

        // latency
        s = out_seen;
        push_exp(32'h0100_FF00);
        @(negedge clk);
        aud_in  = 32'h0100_FF00;
        aud_vld = 1'b1;
        #1;
        chk("lat_busy0", busy, 0);
        chk("lat_ovr0", ovr, 0);
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            aud_vld = 1'b0;
            #1;
            chk($sformatf("lat_busy%0d", k), busy, (k <= 3));
            chk($sformatf("lat_vld%0d", k), out_vld, (k == 3));
        end
        chk("lat_cnt", out_seen - s, 1);
        model_step();

        // overrun
        s = out_seen;
        push_exp(32'h1111_2222);
        @(negedge clk);
        aud_in  = 32'h1111_2222;
        aud_vld = 1'b1;
        @(negedge clk);
        aud_vld = 1'b0;
        #1 chk("ovr_c1", ovr, 0);
        @(negedge clk);
        aud_in  = 32'h7777_7777;
        aud_vld = 1'b1;
        #1 chk("ovr_c2", ovr, 1);
        @(negedge clk);
        aud_vld = 1'b0;
        #1 chk("ovr_vld3", out_vld, 1);
        repeat (4) @(negedge clk);
        #1;
        chk("ovr_cnt", out_seen - s, 1);
        chk("ovr_idle", busy, 0);
        model_step();

        // mute ramp down then back up
        mute = 1'b1;
        for (int i = 0; i < 32; i++) run_frame(32'h4000_C000);
        chk("mute_gain", gain, 0);
        run_frame(32'h4000_C000);
        mute = 1'b0;
        for (int i = 0; i < 33; i++) run_frame(32'h0200_FE00);
        chk("unmute_gain", gain, 12'd2048);

        // saturation at max gain
        volume = 12'd0;
        for (int i = 0; i < 32; i++) run_frame(32'h0010_FFF0);
        chk("max_gain", gain, 12'd4095);
        run_frame(32'h9000_7000);
        run_frame(32'hFFFF_0001);

        // reset during MUL
        s = out_seen;
        @(negedge clk);
        aud_in  = 32'h5555_5555;
        aud_vld = 1'b1;
        @(negedge clk);
        aud_vld = 1'b0;
        #1 chk("pre_rst_busy", busy, 1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_out", aud_out, 0);
        chk("mid_rst_gain", gain, 0);
        chk("mid_rst_busy", busy, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        #1 chk("mid_rst_novld", out_seen - s, 0);
        model_gain = 0;
        run_frame(32'h5555_5555);

        if (sb.size() != 0) chk("sb_left", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
